// File: rtl/output_collector_pkg.sv
// Shared types for the output collector: FSM states, buffered entry layout, map size helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package output_collector_pkg;

    // Entry data is stored at a fixed 32-bit width; only the low OUT_WIDTH bits are sent out.
    localparam int ENTRY_DATA_W = 32;
    localparam int COORD_W      = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } oc_state_t;

    typedef struct packed {
        logic [ENTRY_DATA_W-1:0] data;
        logic [COORD_W-1:0]      x;
        logic [COORD_W-1:0]      y;
        logic [COORD_W-1:0]      ch;
        logic                    last;
    } output_entry_t;

    // Number of outputs in one feature map.
    function automatic logic [63:0] calc_total(input int w, input int h, input int c);
        return 64'(w) * 64'(h) * 64'(c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO with flush, full/empty flags and occupancy count.
// Latency: a write at edge N is readable after edge N (no write-to-read bypass).
// Backpressure: a write while full is discarded unless a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             arst_n_in,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_wr;
    logic             do_rd;

    // A read frees a slot in the same cycle, so a write to a full FIFO is legal alongside a read.
    always_comb begin
        do_rd = rd_en && !empty;
        do_wr = wr_en && (!full || rd_en);
    end

    // Storage, pointers and occupancy; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;

endmodule

// File: rtl/output_collector.sv
// Captures finished output pixels, saturates them (optional ReLU via OUTPUT_COLLECTOR_RELU_EN), buffers and drains to host.
// Latency: 1 cycle from in_valid to out_valid; one transfer per cycle sustained.
// Backpressure: never stalls the producer; a write to a full FIFO with no transfer is dropped and sets sticky overflow.
module output_collector
    import output_collector_pkg::*;
#(
    parameter int ACC_WIDTH          = 32,
    parameter int OUT_WIDTH          = 16,
    parameter int FIFO_DEPTH         = 8,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64
) (
    input  logic                        clk,
    input  logic                        arst_n_in,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic signed [ACC_WIDTH-1:0] in_data,
    input  logic [31:0]                 in_x,
    input  logic [31:0]                 in_y,
    input  logic [31:0]                 in_ch,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic [31:0]                 out_x,
    output logic [31:0]                 out_y,
    output logic [31:0]                 out_ch,
    output logic                        out_last,
    output logic                        overflow,
    output logic                        all_done,
    output logic [31:0]                 out_count
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam int          ENTRY_W    = $bits(output_entry_t);
    localparam logic [31:0] TOTAL      = 32'(calc_total(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT,
                                                        OUTPUT_NB_CHANNELS));
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        ACC_WIDTH'(-(64'sd1 <<< (OUT_WIDTH-1)));

    oc_state_t                   st;
    oc_state_t                   st_nxt;
    logic [31:0]                 wr_cnt;
    logic                        xfer;
    logic                        wr_attempt;
    logic                        drop;
    logic signed [ACC_WIDTH-1:0] acc_v;
    logic signed [OUT_WIDTH-1:0] sat_val;
    output_entry_t               wr_entry;
    output_entry_t               rd_entry;
    logic [ENTRY_W-1:0]          fifo_rd_data;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [AW:0]                 fifo_level_unused;
    logic                        data_hi_unused;

    assign xfer       = out_valid && out_ready;
    // start flushes everything, so a result arriving in the same cycle is discarded.
    assign wr_attempt = in_valid && (st == ACTIVE) && !start;
    assign drop       = wr_attempt && fifo_full && !xfer;

    // Optional ReLU, then clamp to the signed OUT_WIDTH range.
    always_comb begin
        acc_v = in_data;
`ifdef OUTPUT_COLLECTOR_RELU_EN
        if (in_data < 0) begin
            acc_v = '0;
        end
`endif
        sat_val = acc_v[OUT_WIDTH-1:0];
        if (acc_v > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_WIDTH-1:0];
        end else if (acc_v < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    // Assemble the entry; last marks the final output by write order, including dropped writes.
    always_comb begin
        wr_entry      = '0;
        wr_entry.data = ENTRY_DATA_W'(sat_val);
        wr_entry.x    = in_x;
        wr_entry.y    = in_y;
        wr_entry.ch   = in_ch;
        wr_entry.last = (wr_cnt == TOTAL - 32'd1);
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .clr       (start),
        .wr_en     (wr_attempt),
        .wr_data   (wr_entry),
        .rd_en     (xfer),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level_unused)
    );

    assign rd_entry       = output_entry_t'(fifo_rd_data);
    assign out_valid      = !fifo_empty;
    assign out_data       = rd_entry.data[OUT_WIDTH-1:0];
    assign out_x          = rd_entry.x;
    assign out_y          = rd_entry.y;
    assign out_ch         = rd_entry.ch;
    assign out_last       = rd_entry.last;
    assign all_done       = (st == DONE);
    assign data_hi_unused = ^rd_entry.data;

    // Write counter, transfer counter and sticky overflow; start clears all of them.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wr_cnt    <= '0;
            out_count <= '0;
            overflow  <= 1'b0;
        end else if (start) begin
            wr_cnt    <= '0;
            out_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (wr_attempt) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
            if (xfer) begin
                out_count <= out_count + 32'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            st <= IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    // Next state: start always (re)enters ACTIVE; the transfer reaching TOTAL finishes the map.
    always_comb begin
        st_nxt = st;
        if (start) begin
            st_nxt = ACTIVE;
        end else begin
            case (st)
                ACTIVE: begin
                    if (xfer && (out_count + 32'd1 == TOTAL)) begin
                        st_nxt = DONE;
                    end
                end
                default: st_nxt = st;
            endcase
        end
    end

endmodule

// File: tb/tb_output_collector.sv
// Directed bench for output_collector on a 2x2x2 map (TOTAL 8), FIFO depth 8.
// Latency: inputs driven 1 time unit after posedge, outputs sampled at the same point.
// Backpressure: out_ready driven directly by the test sequences.
module tb_output_collector;

    logic               clk = 1'b0;
    logic               arst_n_in;
    logic               start;
    logic               in_valid;
    logic signed [31:0] in_data;
    logic [31:0]        in_x, in_y, in_ch;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic [31:0]        out_x, out_y, out_ch;
    logic               out_last;
    logic               overflow;
    logic               all_done;
    logic [31:0]        out_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int din;
        int x;
        int y;
        int ch;
        int exp;
    } vec_t;

    vec_t tbl[7];

    output_collector #(
        .ACC_WIDTH          (32),
        .OUT_WIDTH          (16),
        .FIFO_DEPTH         (8),
        .FEATURE_MAP_WIDTH  (2),
        .FEATURE_MAP_HEIGHT (2),
        .OUTPUT_NB_CHANNELS (2)
    ) dut (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_ch     (in_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .overflow  (overflow),
        .all_done  (all_done),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wr(input int d, input int x, input int y, input int c);
        in_valid = 1'b1;
        in_data  = d;
        in_x     = x;
        in_y     = y;
        in_ch    = c;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int rcv;
        int exp_d;
        bit saw_last;

        tbl[0] = '{40000,   1, 11, 0, 32767};
        tbl[1] = '{-40000,  2, 12, 1, -32768};
        tbl[2] = '{123,     3, 13, 0, 123};
        tbl[3] = '{32767,   4, 14, 1, 32767};
        tbl[4] = '{32768,   5, 15, 0, 32767};
        tbl[5] = '{-32768,  6, 16, 1, -32768};
        tbl[6] = '{-1,      7, 17, 0, -1};

        arst_n_in = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_x      = '0;
        in_y      = '0;
        in_ch     = '0;
        out_ready = 1'b0;

        // Reset values
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_all_done", int'(all_done), 0);
        chk("rst_out_count", int'(out_count), 0);
        arst_n_in = 1'b1;
        tick();

        // IDLE ignores in_valid
        wr(5, 0, 0, 0);
        chk("idle_ignore_valid", int'(out_valid), 0);

        // Saturation table
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            wr(tbl[i].din, tbl[i].x, tbl[i].y, tbl[i].ch);
            if (i == 0) chk("sat_first_visible", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            exp_d = tbl[i].exp;
`ifdef OUTPUT_COLLECTOR_RELU_EN
            if (tbl[i].din < 0) exp_d = 0;
`endif
            chk("sat_valid", int'(out_valid), 1);
            chk("sat_data", int'(out_data), exp_d);
            chk("sat_x", int'(out_x), tbl[i].x);
            chk("sat_y", int'(out_y), tbl[i].y);
            chk("sat_ch", int'(out_ch), tbl[i].ch);
            chk("sat_last", int'(out_last), 0);
            tick();
        end
        out_ready = 1'b0;
        chk("sat_empty", int'(out_valid), 0);
        chk("sat_count", int'(out_count), 7);

        // Back-pressure and overflow
        pulse_start();
        for (int i = 0; i < 8; i++) wr(10 * i + 1, i, 0, 0);
        chk("bp_no_overflow", int'(overflow), 0);
        wr(999, 9, 0, 0);
        chk("bp_overflow", int'(overflow), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_data", int'(out_data), 10 * i + 1);
            chk("bp_last", int'(out_last), (i == 7) ? 1 : 0);
            tick();
        end
        out_ready = 1'b0;
        chk("bp_drained", int'(out_valid), 0);
        chk("bp_count", int'(out_count), 8);
        chk("bp_done", int'(all_done), 1);

        // Full FIFO with simultaneous write and transfer
        pulse_start();
        for (int i = 0; i < 8; i++) wr(200 + i, i, 0, 0);
        out_ready = 1'b1;
        wr(299, 8, 0, 0);
        out_ready = 1'b0;
        chk("sim_no_overflow", int'(overflow), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("sim_valid", int'(out_valid), 1);
            chk("sim_data", int'(out_data), (i == 7) ? 299 : 201 + i);
            tick();
        end
        out_ready = 1'b0;
        chk("sim_drained", int'(out_valid), 0);

        // Completion on a full 2x2x2 map with out_ready high
        pulse_start();
        out_ready = 1'b1;
        rcv = 0;
        saw_last = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 8);
            in_data  = 100 + i;
            in_x     = i;
            in_y     = 0;
            in_ch    = 0;
            saw_last = 1'b0;
            if (out_valid) begin
                chk("cmp_data", int'(out_data), 100 + rcv);
                chk("cmp_last", int'(out_last), (rcv == 7) ? 1 : 0);
                if (out_last) begin
                    saw_last = 1'b1;
                    chk("cmp_not_done_yet", int'(all_done), 0);
                end
                rcv++;
            end
            tick();
            if (saw_last) chk("cmp_done_rise", int'(all_done), 1);
        end
        in_valid = 1'b0;
        chk("cmp_received", rcv, 8);
        chk("cmp_count", int'(out_count), 8);
        wr(42, 0, 0, 0);
        chk("done_ignore_valid", int'(out_valid), 0);
        chk("done_no_overflow", int'(overflow), 0);
        chk("done_hold", int'(all_done), 1);
        chk("done_count_hold", int'(out_count), 8);
        out_ready = 1'b0;

        // Mid-run restart with buffered entries and overflow set
        pulse_start();
        for (int i = 0; i < 9; i++) wr(300 + i, i, 0, 0);
        chk("rs_overflow_set", int'(overflow), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("rs_count_before", int'(out_count), 1);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 77;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("rs_valid_cleared", int'(out_valid), 0);
        chk("rs_count_cleared", int'(out_count), 0);
        chk("rs_overflow_cleared", int'(overflow), 0);
        chk("rs_not_done", int'(all_done), 0);
        wr(55, 3, 4, 1);
        chk("rs_active_write", int'(out_valid), 1);
        chk("rs_active_data", int'(out_data), 55);
        chk("rs_active_last", int'(out_last), 0);

        // Asynchronous reset in the middle of a transfer sequence
        wr(56, 5, 6, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ar_pre_valid", int'(out_valid), 1);
        chk("ar_pre_count", int'(out_count), 1);
        #2;
        arst_n_in = 1'b0;
        #1;
        chk("ar_valid", int'(out_valid), 0);
        chk("ar_data", int'(out_data), 0);
        chk("ar_x", int'(out_x), 0);
        chk("ar_last", int'(out_last), 0);
        chk("ar_count", int'(out_count), 0);
        chk("ar_overflow", int'(overflow), 0);
        chk("ar_done", int'(all_done), 0);
        #3;
        arst_n_in = 1'b1;
        tick();
        wr(9, 0, 0, 0);
        chk("ar_idle_ignore", int'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_collector.md
# output_collector

Downstream stage of the convolution controller and MAC datapath. Captures every finished output pixel: accumulator value plus x/y/output-channel coordinates, qualified by the controller's one-cycle output-valid pulse. It saturates each value to the external output width and buffers results in a small FIFO. It drains them to the host over a valid/ready interface, counts the full feature map and flags completion. The controller cannot stall, so a full FIFO sets a sticky overflow flag instead of applying back-pressure.

## Interface
- ACC_WIDTH, 32, accumulator width of incoming results
- OUT_WIDTH, 16, width of values sent to host
- FIFO_DEPTH, 8, entries; power of two, at least 2
- FEATURE_MAP_WIDTH, 1024, output x extent
- FEATURE_MAP_HEIGHT, 1024, output y extent
- OUTPUT_NB_CHANNELS, 64, output channel count
- clk  in  1  clock
- arst_n_in  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; flushes the FIFO, clears counters and flags, enters ACTIVE
- in_valid  in  1  result-valid pulse from controller
- in_data  in  ACC_WIDTH  signed accumulator result
- in_x, in_y, in_ch  in  32 each  result coordinates
- out_valid  out  1  head entry available
- out_ready  in  1  host accepts head entry
- out_data  out  OUT_WIDTH  signed, saturated value
- out_x, out_y, out_ch  out  32 each  head-entry coordinates
- out_last  out  1  head entry is the final output of the map
- overflow  out  1  sticky; a result was dropped
- all_done  out  1  every output has been transferred to the host
- out_count  out  32  number of entries transferred since start

## Operation
- States: IDLE, ACTIVE, DONE. Reset leads to IDLE.
  - IDLE: start moves to ACTIVE.
  - ACTIVE: the transfer that raises out_count to TOTAL = FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS moves to DONE.
  - DONE: start moves to ACTIVE.
- in_valid is ignored in IDLE and DONE. It is not counted and does not set overflow.
- ACTIVE write: in_valid writes one entry {sat(in_data), in_x, in_y, in_ch, last}.
  - last is set when the write count since start equals TOTAL-1.
- Saturation: values above 2^(OUT_WIDTH-1)-1 clamp to that maximum; values below -2^(OUT_WIDTH-1) clamp to that minimum; all others pass through unchanged (sign-preserving truncation).
- Transfer = out_valid && out_ready. Each transfer pops one entry and increments out_count.
- Full FIFO:
  - Full with in_valid and no transfer in the same cycle: the entry is dropped, overflow sets, and the write counter still increments so out_last stays aligned with coordinates.
  - Full with in_valid and a transfer in the same cycle: the write is accepted and nothing is dropped.
- Empty FIFO: out_valid is 0. There is no write-to-read bypass.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
- start in any state, including mid-operation:
  - FIFO emptied; out_count, write counter and overflow cleared; state becomes ACTIVE.
  - An in_valid in the same cycle is dropped.
- all_done is 1 in DONE only.

## Timing
- Reset values: out_valid 0, out_data 0, out_x/out_y/out_ch 0, out_last 0, overflow 0, all_done 0, out_count 0. State IDLE.
- Write-to-out_valid latency is 1 cycle: an entry written at edge N is visible after edge N.
- out_data, coordinates and out_last hold stable while out_valid && !out_ready.
- Sustained throughput is one transfer per cycle with out_ready held high.
- overflow sets at the edge following the drop.
- all_done rises at the edge following the final transfer.
- out_count updates at the edge of each transfer.

## Configuration
- OUTPUT_COLLECTOR_RELU_EN defined: negative in_data becomes 0 before saturation, so out_data is never negative.
- OUTPUT_COLLECTOR_RELU_EN undefined: signed saturation only.

## Structure
- Shared package holds:
  - the state enum {IDLE, ACTIVE, DONE};
  - the packed struct output_entry_t {data, x, y, ch, last};
  - the function computing TOTAL.
- One sub-module, sync_fifo, parameterized by entry type/width and depth. It is register-based and provides full, empty and occupancy outputs.
- Saturation, the counters and the FSM live in output_collector.

## Test plan
- Saturation: reset, start, in_data = 40000, -40000 and 123 with OUT_WIDTH 16 -> out_data 32767, -32768, 123 with coordinates preserved; with RELU_EN, -40000 -> 0.
- Back-pressure: out_ready=0, 8 pulses into depth 8 -> all held, overflow 0; a 9th pulse -> overflow 1 next cycle; draining yields the first 8 in order.
- Full-boundary simultaneity: FIFO full, in_valid and a transfer in the same cycle -> no overflow, occupancy stays 8.
- Completion: a 2x2x2 map (TOTAL 8) streamed with out_ready=1 -> out_last only on entry 8, all_done 1 cycle later, out_count 8; further in_valid ignored.
- Mid-run restart: start after 3 of 8 entries with 2 buffered -> out_valid 0 next cycle, out_count 0, overflow cleared, state ACTIVE.
- Reset mid-transfer: arst_n_in low while out_valid=1 -> all outputs at reset values immediately, IDLE.
